wptr_handler: RTL
=================

Name: wptr_handler

Overview:
Write-domain pointer and flag logic for the asynchronous FIFO. It is the write-side counterpart to the read-pointer handler. It advances the binary and Gray write pointers on accepted writes and compares the Gray write pointer with the read pointer synchronised into wclk to produce full. It also derives a pessimistic fill level, almost_full, a memory write-enable and a sticky overflow error flag.

Parameters:
PTR_WIDTH, 3, address width; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits; legal range >= 2
AFULL_THRESH, 6, wr_level value at or above which almost_full asserts; legal range 1..2**PTR_WIDTH

Ports:
wclk  input  1  write-domain clock, all state on rising edge
w_rstn  input  1  asynchronous active-low reset
wen  input  1  write request from producer
ovf_clr  input  1  clears sticky overflow flag
g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer after 2-flop synchroniser into wclk
b_wptr  output  PTR_WIDTH+1  binary write pointer; low PTR_WIDTH bits form the memory write address
g_wptr  output  PTR_WIDTH+1  Gray write pointer, registered, sent to read-domain synchroniser
wr_mem_en  output  1  combinational wen & ~full; memory write strobe
full  output  1  registered full flag
almost_full  output  1  registered, wr_level >= AFULL_THRESH
wr_level  output  PTR_WIDTH+1  registered occupancy estimate, 0..2**PTR_WIDTH
overflow  output  1  sticky; write attempted while full

Behaviour:
- Reset (w_rstn low, asynchronous, also mid-operation): b_wptr=0, g_wptr=0, full=0, almost_full=0, wr_level=0, overflow=0. Outputs clear immediately, with no clock required. The first edge after deassertion behaves as normal operation.
- Accept: acc = wen & ~full.
- b_wptr_next = b_wptr + acc, modulo 2**(PTR_WIDTH+1). The MSB is the wrap bit.
- g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next.
- Every wclk edge: b_wptr <= b_wptr_next and g_wptr <= g_wptr_next. g_wptr must never change by more than one bit per edge.
- full_next = (g_wptr_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}).
- full <= full_next every edge, not only on writes. full therefore asserts on the same edge that accepts the final write, and deasserts one edge after g_rptr_sync moves.
- b_rptr_sync = Gray-to-binary of g_rptr_sync: bit i = XOR of g_rptr_sync[PTR_WIDTH:i].
- wr_level <= b_wptr_next - b_rptr_sync, PTR_WIDTH+1-bit wrap-around subtraction. Because of synchroniser lag this over-estimates occupancy and never under-estimates it.
- almost_full <= (wr_level_next >= AFULL_THRESH). It updates on the same edge as wr_level.
- Write while full (wen=1, full=1): no pointer change and wr_mem_en=0; overflow <= 1.
- ovf_clr: overflow <= 0. If set and clear occur in the same cycle, set wins.
- Wrap-around: b_wptr goes 2*DEPTH-1 -> 0 and g_wptr goes {1,0..0} -> 0 with a single-bit change. full detection is correct across the wrap.
- g_rptr_sync changing in the same cycle as an accepted write: both are used in the same next-state compute. There is no priority, and the level equals the exact difference of the two next values.
- wen high continuously while full: no pointer motion and overflow stays set. Writes resume on the first edge where full=0.

Optional Feature:
Macro WPTR_OVF_CNT_EN.
- Defined: adds output ovf_cnt [7:0]. It increments on each cycle with wen & full, saturates at 255, and is cleared by ovf_clr (set-wins rule does not apply; clear has priority for the count). Its reset value is 0.
- Undefined: the port and counter are absent, and the overflow flag behaviour is unchanged.

Test Plan:
- Reset: hold w_rstn=0, toggle wen -> all outputs 0. Deassert with g_rptr_sync=0 -> full=0, wr_level=0.
- Fill: g_rptr_sync=0, wen=1 for 8 cycles -> b_wptr=8, g_wptr=4'b1100, full=1 on the 8th accepting edge, wr_level=8, almost_full=1 from wr_level=6.
- Overflow: with full=1, wen=1 for 3 cycles -> b_wptr stays 8, wr_mem_en=0, overflow=1. ovf_clr pulse -> overflow=0. Simultaneous ovf_clr and wen&full -> overflow stays 1. With WPTR_OVF_CNT_EN, ovf_cnt=3, then 0 after the clear.
- Drain release: from full, drive g_rptr_sync=4'b0001 (read ptr 1) -> full=0 and wr_level=7 one edge later; almost_full stays 1.
- Wrap: interleave writes with g_rptr_sync tracking 4 behind for 20 writes -> b_wptr wraps 15->0 with g_wptr 4'b1000->4'b0000, full never asserts, wr_level constant at 4. Check that g_wptr changes by exactly one bit per accepted write.
- Reset mid-operation: assert w_rstn low asynchronously between clock edges while full=1, overflow=1 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/wptr_handler.sv
// Write-side pointer, full/level and overflow logic for the async FIFO.
// Optional macro WPTR_OVF_CNT_EN adds a saturating overflow event counter.
module wptr_handler #(
   parameter int PTR_WIDTH    = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic               wclk,
   input  logic               w_rstn,
   input  logic               wen,
   input  logic               ovf_clr,
   input  logic [PTR_WIDTH:0] g_rptr_sync,
   output logic [PTR_WIDTH:0] b_wptr,
   output logic [PTR_WIDTH:0] g_wptr,
   output logic               wr_mem_en,
   output logic               full,
   output logic               almost_full,
   output logic [PTR_WIDTH:0] wr_level,
`ifdef WPTR_OVF_CNT_EN
   output logic [7:0]         ovf_cnt,
`endif
   output logic               overflow
);

   localparam logic [PTR_WIDTH:0] AF_TH = (PTR_WIDTH+1)'(AFULL_THRESH);

   logic               acc;
   logic               ovf_evt;
   logic               full_next;
   logic               afull_next;
   logic [PTR_WIDTH:0] b_wptr_next;
   logic [PTR_WIDTH:0] g_wptr_next;
   logic [PTR_WIDTH:0] b_rptr_sync;
   logic [PTR_WIDTH:0] level_next;

   assign acc       = wen & ~full;
   assign ovf_evt   = wen & full;
   assign wr_mem_en = acc;

   assign b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, acc};
   assign g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;

   // full when the write pointer is exactly one lap ahead of the read pointer
   assign full_next = (g_wptr_next ==
      {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]});

   always_comb begin
      b_rptr_sync = '0;
      for (int i = 0; i <= PTR_WIDTH; i++)
         b_rptr_sync[i] = ^(g_rptr_sync >> i);
   end

   assign level_next = b_wptr_next - b_rptr_sync;
   assign afull_next = (level_next >= AF_TH);

   always_ff @(posedge wclk or negedge w_rstn) begin
      if (!w_rstn) begin
         b_wptr      <= '0;
         g_wptr      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
      end else begin
         b_wptr      <= b_wptr_next;
         g_wptr      <= g_wptr_next;
         full        <= full_next;
         almost_full <= afull_next;
         wr_level    <= level_next;
      end
   end

   // a new overflow event beats a simultaneous clear
   always_ff @(posedge wclk or negedge w_rstn) begin
      if (!w_rstn)
         overflow <= 1'b0;
      else if (ovf_evt)
         overflow <= 1'b1;
      else if (ovf_clr)
         overflow <= 1'b0;
   end

`ifdef WPTR_OVF_CNT_EN
   always_ff @(posedge wclk or negedge w_rstn) begin
      if (!w_rstn)
         ovf_cnt <= '0;
      else if (ovf_clr)
         ovf_cnt <= '0;
      else if (ovf_evt && ovf_cnt != 8'hFF)
         ovf_cnt <= ovf_cnt + 8'd1;
   end
`endif

endmodule
